dht22_reader: RTL and testbench

- Hardware single-wire controller for the DHT22 temperature/humidity sensor on the PMOD JD `temp` pin. It replaces software bit-banging through the tri-state GPIO.
- Sits directly upstream of the embedded system: it drives the top-level tri-state buffer via dq_o/dq_t, samples dq_i, and presents decoded 16-bit humidity/temperature words plus status to a GPIO/register input of embsys.
- One read transaction per start pulse.

---
 rtl/dht22_reader.sv | 199 +++++++++++++++++++
 tb/tb_dht22_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dht22_reader.sv
// DHT22 single-wire reader: issues the host start pulse, times the sensor's
// response and 40 data bits, verifies the checksum and publishes the result.
`timescale 1ns/1ps
module dht22_reader #(
    parameter int CYCLES_PER_US = 100,
    parameter int START_LOW_US  = 1100,
    parameter int BIT_THRESH_US = 48,
    parameter int TIMEOUT_US    = 200,
    parameter int CNT_W         = 20
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        dq_i,
    output logic        dq_o,
    output logic        dq_t,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        err_checksum,
    output logic        data_valid,
    output logic [15:0] humidity,
    output logic [15:0] temperature
);

    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_LOW_US * CYCLES_PER_US - 1);
    localparam logic [CNT_W-1:0] THRESH_CYC  = CNT_W'(BIT_THRESH_US * CYCLES_PER_US);
    localparam logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(TIMEOUT_US * CYCLES_PER_US);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_WAIT_RESP,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [5:0]         r_idx;
    logic [39:0]        r_shift;
    logic               r_dq_meta;
    logic               r_ds;
    logic               r_ds_prev;
    logic               r_dq_t;
    logic               r_busy;
    logic               r_done;
    logic               r_err_timeout;
    logic               r_err_checksum;
    logic               r_data_valid;
    logic [15:0]        r_humidity;
    logic [15:0]        r_temperature;

    logic               w_rise;
    logic               w_fall;
    logic               w_bit;
    logic               w_waiting;
    logic               w_accept;
    logic               w_shift;
    logic               w_timeout;
    logic               w_check;
    logic [7:0]         w_sum;

    // Line idles high through the pull-up, so the synchroniser resets to 1
    // to avoid a phantom falling edge right after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dq_meta <= 1'b1;
            r_ds      <= 1'b1;
            r_ds_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its source, which is what builds a shift chain.
            r_dq_meta <= dq_i;
            r_ds      <= r_dq_meta;
            r_ds_prev <= r_ds;
        end
    end

    assign w_rise = r_ds & ~r_ds_prev;
    assign w_fall = ~r_ds & r_ds_prev;
    assign w_bit  = (r_cnt > THRESH_CYC);
    assign w_sum  = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves a value unassigned and infers a latch.
        w_next    = r_state;
        w_accept  = 1'b0;
        w_shift   = 1'b0;
        w_timeout = 1'b0;
        w_check   = 1'b0;
        w_waiting = (r_state inside {S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH,
                                     S_BIT_LOW, S_BIT_HIGH});
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_START_LOW;
                end
            end
            S_START_LOW: if (r_cnt == START_LAST) w_next = S_WAIT_RESP;
            S_WAIT_RESP: if (w_fall) w_next = S_RESP_LOW;
            S_RESP_LOW:  if (w_rise) w_next = S_RESP_HIGH;
            S_RESP_HIGH: if (w_fall) w_next = S_BIT_LOW;
            S_BIT_LOW:   if (w_rise) w_next = S_BIT_HIGH;
            S_BIT_HIGH: begin
                if (w_fall) begin
                    w_shift = 1'b1;
                    w_next  = (r_idx == 6'd39) ? S_CHECK : S_BIT_LOW;
                end
            end
            S_CHECK: begin
                w_check = 1'b1;
                w_next  = S_FINISH;
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_waiting && (r_cnt > TIMEOUT_CYC)) begin
            w_timeout = 1'b1;
            w_shift   = 1'b0;
            w_next    = S_FINISH;
        end
    end

    // Control outputs are registered from the next state to keep the
    // tri-state enable glitch-free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dq_t  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || (r_state == S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_dq_t <= (w_next != S_START_LOW);
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_FINISH);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx          <= '0;
            r_shift        <= '0;
            r_err_timeout  <= 1'b0;
            r_err_checksum <= 1'b0;
            r_data_valid   <= 1'b0;
            r_humidity     <= '0;
            r_temperature  <= '0;
        end else begin
            if (w_accept) begin
                r_idx          <= '0;
                r_shift        <= '0;
                r_err_timeout  <= 1'b0;
                r_err_checksum <= 1'b0;
            end
            if (w_shift) begin
                r_shift <= {r_shift[38:0], w_bit};
                r_idx   <= r_idx + 6'd1;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
            if (w_check) begin
                if (w_sum == r_shift[7:0]) begin
                    r_humidity    <= r_shift[39:24];
                    r_temperature <= r_shift[23:8];
                    r_data_valid  <= 1'b1;
                end else begin
                    r_err_checksum <= 1'b1;
                end
            end
        end
    end

    assign dq_o         = 1'b0;
    assign dq_t         = r_dq_t;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err_timeout  = r_err_timeout;
    assign err_checksum = r_err_checksum;
    assign data_valid   = r_data_valid;
    assign humidity     = r_humidity;
    assign temperature  = r_temperature;

endmodule

// File: tb/tb_dht22_reader.sv
// Directed bench for dht22_reader with a cycle-timed DHT22 sensor model,
// run at 1 cycle per microsecond to keep frames short.
`timescale 1ns/1ps
module tb_dht22_reader;

    localparam int START_CYC    = 1100;
    localparam int NO_SENSOR_K  = 1302;  // 1100 start low + 202 wait cycles

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        sensor_low;
    logic        dq_i;
    logic        dq_o;
    logic        dq_t;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        err_checksum;
    logic        data_valid;
    logic [15:0] humidity;
    logic [15:0] temperature;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int low_cnt  = 0;
    int t0       = 0;
    int low0     = 0;
    int prev     = 0;

    always #5 clk = ~clk;

    // Open-drain line: low if either side pulls it down, otherwise pull-up.
    assign dq_i = ~((~dq_t & ~dq_o) | sensor_low);

    dht22_reader #(
        .CYCLES_PER_US (1),
        .START_LOW_US  (1100),
        .BIT_THRESH_US (48),
        .TIMEOUT_US    (200),
        .CNT_W         (20)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .dq_i         (dq_i),
        .dq_o         (dq_o),
        .dq_t         (dq_t),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .err_checksum (err_checksum),
        .data_valid   (data_valid),
        .humidity     (humidity),
        .temperature  (temperature)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (!dq_t) low_cnt = low_cnt + 1;
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        t0   = cyc;
        low0 = low_cnt;
        prev = done_cnt;
        #1 start = 1'b0;
    endtask

    task automatic wait_release();
        int n = 0;
        @(negedge clk);
        while (dq_t !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("line_released", (n < 3000), 1'b1);
    endtask

    task automatic send_frame(input logic [39:0] f, input int nbits);
        hold(30);
        sensor_low = 1'b1; hold(80);
        sensor_low = 1'b0; hold(80);
        for (int i = 0; i < nbits; i++) begin
            sensor_low = 1'b1; hold(50);
            sensor_low = 1'b0; hold(f[39-i] ? 70 : 27);
        end
        if (nbits == 40) begin
            sensor_low = 1'b1; hold(50);
            sensor_low = 1'b0;
        end else begin
            hold(300);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == prev && n < 10000) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", (done_cnt != prev), 1'b1);
    endtask

    task automatic run_frame(input logic [39:0] f, input int nbits);
        do_start();
        wait_release();
        send_frame(f, nbits);
        wait_done();
        @(posedge clk);
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        sensor_low = 1'b0;
        hold(3);
        #1;
        check("rst_dq_t", dq_t, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_errs", {err_timeout, err_checksum}, 2'b00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_hum", humidity, 16'h0000);
        check("rst_tmp", temperature, 16'h0000);
        @(negedge clk) resetn = 1'b1;
        hold(5);

        // Negative temperature frame
        run_frame(40'h02_8C_80_65_73, 40);
        check("neg_hum", humidity, 16'h028C);
        check("neg_tmp", temperature, 16'h8065);
        check("neg_errs", {err_timeout, err_checksum}, 2'b00);
        check("neg_valid", data_valid, 1'b1);

        // Good positive frame, also measuring the start pulse length
        run_frame(40'h02_8C_01_5F_EE, 40);
        check("good_low_len", low_cnt - low0, START_CYC);
        check("good_hum", humidity, 16'h028C);
        check("good_tmp", temperature, 16'h015F);
        check("good_errs", {err_timeout, err_checksum}, 2'b00);
        check("good_valid", data_valid, 1'b1);

        // Bad checksum keeps previous data
        run_frame(40'h02_8C_01_5F_EF, 40);
        check("cs_err", err_checksum, 1'b1);
        check("cs_to", err_timeout, 1'b0);
        check("cs_hum", humidity, 16'h028C);
        check("cs_tmp", temperature, 16'h015F);
        check("cs_valid", data_valid, 1'b1);

        // No sensor: only the pull-up answers
        do_start();
        wait_done();
        check("nosens_latency", done_cyc - t0 - 1, NO_SENSOR_K);
        check("nosens_to", err_timeout, 1'b1);
        check("nosens_cs_cleared", err_checksum, 1'b0);
        check("nosens_low_len", low_cnt - low0, START_CYC);
        check("nosens_hum", humidity, 16'h028C);

        // Sensor stalls high during bit 18, then a good frame recovers
        run_frame(40'h02_8C_80_65_73, 17);
        check("stall_to", err_timeout, 1'b1);
        check("stall_tmp", temperature, 16'h015F);
        run_frame(40'h02_8C_80_65_73, 40);
        check("recover_to", err_timeout, 1'b0);
        check("recover_tmp", temperature, 16'h8065);

        // Start pulsed again while bits arrive
        do_start();
        wait_release();
        fork
            send_frame(40'h02_8C_01_5F_EE, 40);
            begin
                hold(600);
                start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
        join
        wait_done();
        hold(1500);
        @(posedge clk);
        check("restart_single_done", done_cnt - prev, 1);
        check("restart_busy", busy, 1'b0);
        check("restart_tmp", temperature, 16'h015F);

        // Reset in the middle of a frame
        do_start();
        wait_release();
        fork
            send_frame(40'h02_8C_01_5F_EE, 40);
            begin
                hold(1000);
                #2 resetn = 1'b0;
                #1;
                check("midrst_dq_t", dq_t, 1'b1);
                check("midrst_busy", busy, 1'b0);
                check("midrst_done", done, 1'b0);
                check("midrst_data", {data_valid, humidity, temperature}, 33'h0);
                check("midrst_errs", {err_timeout, err_checksum}, 2'b00);
            end
        join
        @(negedge clk) resetn = 1'b1;
        hold(200);
        @(posedge clk);
        check("midrst_no_done", done_cnt - prev, 0);
        check("midrst_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
